// File: rtl/demux_pkg.sv
// demux_pkg: shared lane count, select type and one-hot helper for demux_1to4
package demux_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;
  function automatic logic [NUM_LANES-1:0] onehot4(sel_t s);
    return NUM_LANES'(1) << s;
  endfunction
endpackage

// File: rtl/demux_if.sv
// demux_if: demux data/select/lane bundle; master drives in/sel, slave drives out (and out_vld when DEMUX_LANE_VLD_EN)
//   in       DATA_W    data to steer
//   sel      2         lane select
//   out      4*DATA_W  lane i = out[i*DATA_W +: DATA_W]
//   out_vld  4         one-hot of the registered sel (DEMUX_LANE_VLD_EN only)
interface demux_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
);
  logic [DATA_W-1:0] in;
  sel_t sel;
  logic [NUM_LANES*DATA_W-1:0] out;
`ifdef DEMUX_LANE_VLD_EN
  logic [NUM_LANES-1:0] out_vld;
  modport master(output in, sel, input out, out_vld);
  modport slave(input in, sel, output out, out_vld);
`else
  modport master(output in, sel, input out);
  modport slave(input in, sel, output out);
`endif
endinterface

// File: rtl/demux_sel_dec.sv
// demux_sel_dec: combinational 2-to-4 one-hot decoder
//   sel  in   2  lane select
//   dec  out  4  one-hot of sel
module demux_sel_dec
  import demux_pkg::*;
(
  input  sel_t                 sel,
  output logic [NUM_LANES-1:0] dec
);
  always_comb dec = onehot4(sel);
endmodule

// File: rtl/demux_1to4.sv
// demux_1to4: registered 1-to-4 demux, lane[sel] <= in, other lanes <= 0, 1-cycle latency
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset, clears out (and out_vld)
//   bus    slave modport of demux_if: in, sel in; out (and out_vld) registered out
//   optional DEMUX_LANE_VLD_EN adds out_vld = one-hot of sel, registered with out
module demux_1to4
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input logic clk,
  input logic rst_n,
  demux_if.slave bus
);
  logic [NUM_LANES-1:0] dec;
  logic [NUM_LANES*DATA_W-1:0] nxt;
  demux_sel_dec u_dec (.sel(bus.sel), .dec(dec));
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign nxt[i*DATA_W +: DATA_W] = bus.in & {DATA_W{dec[i]}};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out <= '0;
`ifdef DEMUX_LANE_VLD_EN
      bus.out_vld <= '0;
`endif
    end else begin
      bus.out <= nxt;
`ifdef DEMUX_LANE_VLD_EN
      bus.out_vld <= dec;
`endif
    end
endmodule

// File: tb/tb_demux_1to4.sv
// tb_demux_1to4: directed self-checking bench for demux_1to4 at DATA_W=1 and DATA_W=8
module tb_demux_1to4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  demux_if #(.DATA_W(1)) b1 ();
  demux_if #(.DATA_W(8)) b8 ();
  demux_1to4 #(.DATA_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  demux_1to4 #(.DATA_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [3:0] one_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  initial begin
    b1.in = 1'b1;
    b1.sel = 2'd1;
    b8.in = 8'hA5;
    b8.sel = 2'd1;
    #2;
    chk("reset_out", 32'(b1.out), 32'h0);
    chk("reset_out8", b8.out, 32'h0);
`ifdef DEMUX_LANE_VLD_EN
    chk("reset_vld", 32'(b1.out_vld), 32'h0);
`endif
    #1 rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      b1.in = 1'b0;
      b1.sel = 2'(s);
      tick();
      chk($sformatf("zero_sel%0d", s), 32'(b1.out), 32'h0);
    end
    for (int s = 0; s < 4; s++) begin
      b1.in = 1'b1;
      b1.sel = 2'(s);
      tick();
      chk($sformatf("one_sel%0d", s), 32'(b1.out), 32'(one_exp[s]));
`ifdef DEMUX_LANE_VLD_EN
      chk($sformatf("vld_sel%0d", s), 32'(b1.out_vld), 32'(one_exp[s]));
`endif
    end
    b1.in = 1'b0;
    b1.sel = 2'd2;
    tick();
    chk("lat_pre", 32'(b1.out), 32'h0);
    b1.in = 1'b1;
    #2;
    chk("lat_hold", 32'(b1.out), 32'h0);
    tick();
    chk("lat_post", 32'(b1.out), 32'h4);
    b1.sel = 2'd3;
    tick();
    chk("mid_set", 32'(b1.out), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_clr", 32'(b1.out), 32'h0);
`ifdef DEMUX_LANE_VLD_EN
    chk("mid_clr_vld", 32'(b1.out_vld), 32'h0);
`endif
    #1 rst_n = 1'b1;
    tick();
    chk("mid_restore", 32'(b1.out), 32'h8);
    b8.in = 8'hA5;
    b8.sel = 2'd1;
    tick();
    chk("w8_a5_sel1", b8.out, 32'h0000_A500);
    b8.in = 8'h3C;
    b8.sel = 2'd3;
    tick();
    chk("w8_3c_sel3", b8.out, 32'h3C00_0000);
    b8.in = 8'h00;
    b8.sel = 2'd1;
    tick();
    chk("w8_zero_sel1", b8.out, 32'h0);
`ifdef DEMUX_LANE_VLD_EN
    chk("w8_zero_vld", 32'(b8.out_vld), 32'h2);
`endif
    b8.in = 8'hFF;
    b8.sel = 2'd0;
    tick();
    chk("w8_ff_sel0", b8.out, 32'h0000_00FF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
